memory_stage: RTL and testbench

- Pipeline stage between execute and writeback in the RISC-V core.
- Takes the execute result and, for loads/stores, performs one data-memory access over a ready-handshake bus.
- Formats load data (sign/zero extend, byte-lane select) and forwards result, destination register and write enable to writeback.
- Stalls upstream while a memory access is outstanding.

---
 rtl/memory_stage.sv | 259 +++++++++++++++++++++++++
 tb/tb_memory_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: pipeline stage between execute and writeback.
// Non-memory ops pass through with one cycle of latency. A load or store makes
// one data-memory access over a request/ready bus. Load data is formatted here
// (byte-lane select, sign or zero extension).
// Ports:
//   clock, reset_n            - rising-edge clock, synchronous active-low reset
//   valid_in .. funct3        - instruction from execute
//   stall                     - execute must hold (combinational from state)
//   mem_req .. mem_be         - registered data-memory request
//   mem_ready, mem_rdata      - memory completion and read data
//   data_result .. valid_out  - registered result to writeback
//   misaligned_err            - one-cycle pulse with valid_out on a bad access
module memory_stage #(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 valid_in,
  input  logic [WORD_SIZE-1:0] alu_result,
  input  logic [WORD_SIZE-1:0] store_data,
  input  logic [4:0]           reg_dest_in,
  input  logic                 write_enable_in,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [2:0]           funct3,
  output logic                 stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic [3:0]           mem_be,
  input  logic                 mem_ready,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [WORD_SIZE-1:0] data_result,
  output logic [4:0]           reg_dest_out,
  output logic                 write_enable_out,
  output logic                 valid_out,
  output logic                 misaligned_err
);

  localparam int unsigned BE_W  = 4;
  localparam int unsigned REG_W = 5;

  typedef enum logic [0:0] {ST_IDLE, ST_ACCESS} state_t;

  state_t                 r_state;
  logic                   r_mem_req;
  logic                   r_mem_we;
  logic [WORD_SIZE-1:0]   r_mem_addr;
  logic [WORD_SIZE-1:0]   r_mem_wdata;
  logic [BE_W-1:0]        r_mem_be;
  logic [WORD_SIZE-1:0]   r_data_result;
  logic [REG_W-1:0]       r_reg_dest;
  logic                   r_we_out;
  logic                   r_valid_out;
  logic                   r_err;
  // Attributes of the outstanding access, needed to format the load result.
  logic [1:0]             r_lat_off;
  logic [2:0]             r_lat_f3;
  logic [REG_W-1:0]       r_lat_rd;
  logic                   r_lat_we;
  logic                   r_lat_load;

  state_t                 w_state_nxt;
  logic                   w_mem_req_nxt;
  logic                   w_mem_we_nxt;
  logic [WORD_SIZE-1:0]   w_mem_addr_nxt;
  logic [WORD_SIZE-1:0]   w_mem_wdata_nxt;
  logic [BE_W-1:0]        w_mem_be_nxt;
  logic [WORD_SIZE-1:0]   w_data_nxt;
  logic [REG_W-1:0]       w_rd_nxt;
  logic                   w_we_out_nxt;
  logic                   w_valid_nxt;
  logic                   w_err_nxt;
  logic [1:0]             w_lat_off_nxt;
  logic [2:0]             w_lat_f3_nxt;
  logic [REG_W-1:0]       w_lat_rd_nxt;
  logic                   w_lat_we_nxt;
  logic                   w_lat_load_nxt;

  logic                   w_is_load;
  logic                   w_is_store;
  logic                   w_is_mem;
  logic [1:0]             w_off;
  logic                   w_bad;
  logic [BE_W-1:0]        w_st_be;
  logic [WORD_SIZE-1:0]   w_st_wdata;
  logic [7:0]             w_ld_byte;
  logic [15:0]            w_ld_half;
  logic [WORD_SIZE-1:0]   w_ld_data;

  assign stall          = (r_state == ST_ACCESS);
  assign mem_req        = r_mem_req;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;
  assign mem_be         = r_mem_be;
  assign data_result    = r_data_result;
  assign reg_dest_out   = r_reg_dest;
  assign write_enable_out = r_we_out;
  assign valid_out      = r_valid_out;
  assign misaligned_err = r_err;

  // Load wins when both mem_read and mem_write are set.
  assign w_is_load  = mem_read;
  assign w_is_store = mem_write & ~mem_read;
  assign w_is_mem   = mem_read | mem_write;
  assign w_off      = alu_result[1:0];

  // Illegal encodings and natural-alignment violations.
  always_comb begin
    w_bad = 1'b0;
    if (w_is_load) begin
      w_bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end else begin
      w_bad = funct3[2] || (funct3[1:0] == 2'b11);
    end
    case (funct3[1:0])
      2'b01:   if (alu_result[0])    w_bad = 1'b1;
      2'b10:   if (|alu_result[1:0]) w_bad = 1'b1;
      default: ;
    endcase
  end

  // Store lanes: data replicated across the word, enables pick the lane.
  always_comb begin
    w_st_be    = 4'b1111;
    w_st_wdata = store_data;
    if (w_is_store) begin
      case (funct3[1:0])
        2'b00: begin
          w_st_be    = BE_W'(4'b0001 << w_off);
          w_st_wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          w_st_be    = BE_W'(4'b0011 << {w_off[1], 1'b0});
          w_st_wdata = {2{store_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load formatting from the offset latched at accept time.
  assign w_ld_byte = mem_rdata[{r_lat_off, 3'b000} +: 8];
  assign w_ld_half = r_lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_ld_data = mem_rdata;
    case (r_lat_f3)
      3'b000:  w_ld_data = {{(WORD_SIZE-8){w_ld_byte[7]}}, w_ld_byte};
      3'b100:  w_ld_data = {{(WORD_SIZE-8){1'b0}}, w_ld_byte};
      3'b001:  w_ld_data = {{(WORD_SIZE-16){w_ld_half[15]}}, w_ld_half};
      3'b101:  w_ld_data = {{(WORD_SIZE-16){1'b0}}, w_ld_half};
      default: w_ld_data = mem_rdata;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_be_nxt    = r_mem_be;
    w_data_nxt      = r_data_result;
    w_rd_nxt        = r_reg_dest;
    w_we_out_nxt    = 1'b0;
    w_valid_nxt     = 1'b0;
    w_err_nxt       = 1'b0;
    w_lat_off_nxt   = r_lat_off;
    w_lat_f3_nxt    = r_lat_f3;
    w_lat_rd_nxt    = r_lat_rd;
    w_lat_we_nxt    = r_lat_we;
    w_lat_load_nxt  = r_lat_load;

    case (r_state)
      ST_IDLE: begin
        if (valid_in) begin
          if (!w_is_mem) begin
            w_valid_nxt  = 1'b1;
            w_data_nxt   = alu_result;
            w_rd_nxt     = reg_dest_in;
            w_we_out_nxt = write_enable_in;
          end else if (w_bad) begin
            w_valid_nxt  = 1'b1;
            w_err_nxt    = 1'b1;
            w_data_nxt   = alu_result;
            w_rd_nxt     = reg_dest_in;
          end else begin
            w_state_nxt     = ST_ACCESS;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = w_is_store;
            w_mem_addr_nxt  = {alu_result[WORD_SIZE-1:2], 2'b00};
            w_mem_wdata_nxt = w_st_wdata;
            w_mem_be_nxt    = w_st_be;
            w_lat_off_nxt   = w_off;
            w_lat_f3_nxt    = funct3;
            w_lat_rd_nxt    = reg_dest_in;
            w_lat_we_nxt    = write_enable_in;
            w_lat_load_nxt  = w_is_load;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ready) begin
          w_state_nxt   = ST_IDLE;
          w_mem_req_nxt = 1'b0;
          w_valid_nxt   = 1'b1;
          w_rd_nxt      = r_lat_rd;
          w_data_nxt    = r_lat_load ? w_ld_data : '0;
          w_we_out_nxt  = r_lat_load & r_lat_we;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_be      <= '0;
      r_data_result <= '0;
      r_reg_dest    <= '0;
      r_we_out      <= 1'b0;
      r_valid_out   <= 1'b0;
      r_err         <= 1'b0;
      r_lat_off     <= '0;
      r_lat_f3      <= '0;
      r_lat_rd      <= '0;
      r_lat_we      <= 1'b0;
      r_lat_load    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_mem_we      <= w_mem_we_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_mem_be      <= w_mem_be_nxt;
      r_data_result <= w_data_nxt;
      r_reg_dest    <= w_rd_nxt;
      r_we_out      <= w_we_out_nxt;
      r_valid_out   <= w_valid_nxt;
      r_err         <= w_err_nxt;
      r_lat_off     <= w_lat_off_nxt;
      r_lat_f3      <= w_lat_f3_nxt;
      r_lat_rd      <= w_lat_rd_nxt;
      r_lat_we      <= w_lat_we_nxt;
      r_lat_load    <= w_lat_load_nxt;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: stimulus pushes expected results, memory
// requests and memory responses into queues; monitors pop and compare.
module tb_memory_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        valid_in;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  reg_dest_in;
  logic        write_enable_in;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] data_result;
  logic [4:0]  reg_dest_out;
  logic        write_enable_out;
  logic        valid_out;
  logic        misaligned_err;

  memory_stage #(.WORD_SIZE(32)) dut (
    .clock(clock), .reset_n(reset_n), .valid_in(valid_in),
    .alu_result(alu_result), .store_data(store_data),
    .reg_dest_in(reg_dest_in), .write_enable_in(write_enable_in),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .data_result(data_result),
    .reg_dest_out(reg_dest_out), .write_enable_out(write_enable_out),
    .valid_out(valid_out), .misaligned_err(misaligned_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data; logic [4:0] rd; logic we; logic err; int stall_n; bit chk_rd;
  } exp_t;
  typedef struct {
    logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; bit chk_wdata; bit b2b;
  } req_t;
  typedef struct { int wait_n; logic [31:0] rdata; } rsp_t;

  exp_t exp_q[$];
  req_t req_q[$];
  rsp_t rsp_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_valid_cyc = -100;
  int stall_cnt = 0;
  logic prev_req = 1'b0;
  bit   have_req = 0;
  req_t cur_req;
  rsp_t cur_rsp;
  bit   rsp_active = 0;
  int   rsp_cnt = 0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"},   32'(stall), 0);
    check({tag, "_req"},     32'(mem_req), 0);
    check({tag, "_we"},      32'(mem_we), 0);
    check({tag, "_addr"},    mem_addr, 0);
    check({tag, "_wdata"},   mem_wdata, 0);
    check({tag, "_be"},      32'(mem_be), 0);
    check({tag, "_data"},    data_result, 0);
    check({tag, "_rd"},      32'(reg_dest_out), 0);
    check({tag, "_weout"},   32'(write_enable_out), 0);
    check({tag, "_valid"},   32'(valid_out), 0);
    check({tag, "_err"},     32'(misaligned_err), 0);
  endtask

  // Result monitor and request monitor.
  always @(negedge clock) begin
    exp_t e;
    req_t r;
    if (reset_n) begin
      if (valid_out) begin
        if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("data_result", data_result, e.data);
          if (e.chk_rd) check("reg_dest_out", 32'(reg_dest_out), 32'(e.rd));
          check("write_enable_out", 32'(write_enable_out), 32'(e.we));
          check("misaligned_err", 32'(misaligned_err), 32'(e.err));
          check("stall_cycles", 32'(stall_cnt), 32'(e.stall_n));
        end
        last_valid_cyc = cyc;
      end else begin
        check("idle_weout", 32'(write_enable_out), 0);
        check("idle_err", 32'(misaligned_err), 0);
      end
      if (stall) stall_cnt++; else stall_cnt = 0;

      if (mem_req && !prev_req) begin
        if (req_q.size() == 0) begin
          check("unexpected_req", 1, 0);
          have_req = 0;
        end else begin
          r = req_q.pop_front();
          cur_req = r;
          have_req = 1;
          if (r.b2b) check("b2b_gap", 32'(cyc - last_valid_cyc), 1);
        end
      end
      if (mem_req && have_req) begin
        check("mem_addr", mem_addr, cur_req.addr);
        check("mem_we", 32'(mem_we), 32'(cur_req.we));
        check("mem_be", 32'(mem_be), 32'(cur_req.be));
        if (cur_req.chk_wdata) check("mem_wdata", mem_wdata, cur_req.wdata);
      end
      if (!mem_req) have_req = 0;
    end
    prev_req = mem_req;
  end

  // Memory responder: waits the queued number of cycles, then returns data.
  always @(negedge clock) begin
    if (mem_req && reset_n) begin
      if (!rsp_active) begin
        if (rsp_q.size() > 0) cur_rsp = rsp_q.pop_front();
        else begin cur_rsp.wait_n = 0; cur_rsp.rdata = 32'h0; end
        rsp_active = 1;
        rsp_cnt = 0;
      end
      if (rsp_cnt >= cur_rsp.wait_n) begin
        mem_ready = 1'b1;
        mem_rdata = cur_rsp.rdata;
        rsp_active = 0;
      end else begin
        mem_ready = 1'b0;
        rsp_cnt++;
      end
    end else begin
      mem_ready = 1'b0;
      rsp_active = 0;
    end
  end

  task automatic issue(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] rd, input logic we);
    int n = 0;
    @(negedge clock);
    while (stall && n < 200) begin @(negedge clock); n++; end
    if (n >= 200) check("issue_timeout", 1, 0);
    alu_result = alu; store_data = sd; reg_dest_in = rd; write_enable_in = we;
    mem_read = rd_op; mem_write = wr_op; funct3 = f3; valid_in = 1'b1;
    @(negedge clock);
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [4:0] rd, input logic we,
                          input logic err, input int st, input bit chk_rd);
    exp_t e;
    e.data = d; e.rd = rd; e.we = we; e.err = err; e.stall_n = st; e.chk_rd = chk_rd;
    exp_q.push_back(e);
  endtask

  task automatic push_req(input logic [31:0] a, input logic we, input logic [3:0] be,
                          input logic [31:0] wd, input bit chk_wd, input bit b2b,
                          input int wait_n, input logic [31:0] rdata);
    req_t r;
    rsp_t s;
    r.addr = a; r.we = we; r.be = be; r.wdata = wd; r.chk_wdata = chk_wd; r.b2b = b2b;
    s.wait_n = wait_n; s.rdata = rdata;
    req_q.push_back(r);
    rsp_q.push_back(s);
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0; valid_in = 1'b0; alu_result = '0; store_data = '0;
    reg_dest_in = '0; write_enable_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;

    // ADD pass-through
    push_exp(32'h0000_1234, 5'd5, 1'b1, 1'b0, 0, 1);
    issue(0, 0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);

    // LB / LBU at offset 3
    push_req(32'h100, 0, 4'b1111, 0, 0, 0, 3, 32'h80FF_0000);
    push_exp(32'hFFFF_FF80, 5'd7, 1'b1, 1'b0, 4, 1);
    issue(1, 0, 3'b000, 32'h103, 32'h0, 5'd7, 1'b1);
    push_req(32'h100, 0, 4'b1111, 0, 0, 0, 0, 32'h80FF_0000);
    push_exp(32'h0000_0080, 5'd8, 1'b1, 1'b0, 1, 1);
    issue(1, 0, 3'b100, 32'h103, 32'h0, 5'd8, 1'b1);

    // Stores: SH upper half, SB lane 1, SW
    push_req(32'h200, 1, 4'b1100, 32'hBEEF_BEEF, 1, 0, 0, 32'h0);
    push_exp(32'h0, 5'd3, 1'b0, 1'b0, 1, 0);
    issue(0, 1, 3'b001, 32'h202, 32'hDEAD_BEEF, 5'd3, 1'b1);
    push_req(32'h0A0, 1, 4'b0010, 32'h7878_7878, 1, 0, 2, 32'h0);
    push_exp(32'h0, 5'd4, 1'b0, 1'b0, 3, 0);
    issue(0, 1, 3'b000, 32'h0A1, 32'h1234_5678, 5'd4, 1'b1);
    push_req(32'h0B0, 1, 4'b1111, 32'hCAFE_F00D, 1, 0, 1, 32'h0);
    push_exp(32'h0, 5'd6, 1'b0, 1'b0, 2, 0);
    issue(0, 1, 3'b010, 32'h0B0, 32'hCAFE_F00D, 5'd6, 1'b0);

    // LH upper half (sign), LHU lower half (zero)
    push_req(32'h100, 0, 4'b1111, 0, 0, 0, 1, 32'h80FF_0000);
    push_exp(32'hFFFF_80FF, 5'd9, 1'b1, 1'b0, 2, 1);
    issue(1, 0, 3'b001, 32'h102, 32'h0, 5'd9, 1'b1);
    push_req(32'h100, 0, 4'b1111, 0, 0, 0, 0, 32'h80FF_8001);
    push_exp(32'h0000_8001, 5'd10, 1'b1, 1'b0, 1, 1);
    issue(1, 0, 3'b101, 32'h100, 32'h0, 5'd10, 1'b1);

    // Error path: misaligned LW, misaligned LHU, illegal store, illegal load
    push_exp(32'h301, 5'd11, 1'b0, 1'b1, 0, 0);
    issue(1, 0, 3'b010, 32'h301, 32'h0, 5'd11, 1'b1);
    push_exp(32'h101, 5'd12, 1'b0, 1'b1, 0, 0);
    issue(1, 0, 3'b101, 32'h101, 32'h0, 5'd12, 1'b1);
    push_exp(32'h60, 5'd13, 1'b0, 1'b1, 0, 0);
    issue(0, 1, 3'b011, 32'h60, 32'h5555_AAAA, 5'd13, 1'b1);
    push_exp(32'h70, 5'd14, 1'b0, 1'b1, 0, 0);
    issue(1, 0, 3'b110, 32'h70, 32'h0, 5'd14, 1'b1);

    // Reset during a stalled access
    push_req(32'h500, 0, 4'b1111, 0, 0, 0, 1000, 32'h0);
    issue(1, 0, 3'b010, 32'h500, 32'h0, 5'd15, 1'b1);
    repeat (3) @(negedge clock);
    check("access_stall", 32'(stall), 1);
    reset_n = 1'b0;
    @(negedge clock);
    check_all_zero("midreset");
    reset_n = 1'b1;
    push_exp(32'hABCD_0001, 5'd31, 1'b1, 1'b0, 0, 1);
    issue(0, 0, 3'b000, 32'hABCD_0001, 32'h0, 5'd31, 1'b1);

    // read+write treated as load, then back-to-back loads
    push_req(32'h40, 0, 4'b1111, 0, 0, 0, 0, 32'h1122_3344);
    push_exp(32'h1122_3344, 5'd1, 1'b1, 1'b0, 1, 1);
    issue(1, 1, 3'b010, 32'h40, 32'hFFFF_FFFF, 5'd1, 1'b1);
    push_req(32'h44, 0, 4'b1111, 0, 0, 1, 1, 32'h5566_7788);
    push_exp(32'h5566_7788, 5'd2, 1'b1, 1'b0, 2, 1);
    issue(1, 0, 3'b010, 32'h44, 32'h0, 5'd2, 1'b1);
    push_req(32'h48, 0, 4'b1111, 0, 0, 1, 0, 32'h99AA_BBCC);
    push_exp(32'hFFFF_FFCC, 5'd3, 1'b1, 1'b0, 1, 1);
    issue(1, 0, 3'b000, 32'h48, 32'h0, 5'd3, 1'b1);

    n = 0;
    while ((exp_q.size() != 0 || req_q.size() != 0) && n < 500) begin
      @(negedge clock);
      n++;
    end
    check("drain_results", 32'(exp_q.size()), 0);
    check("drain_requests", 32'(req_q.size()), 0);
    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
